// File: rtl/pixel_packet_writer_if.sv
// Byte-stream link feeding the pixel packet writer.
// The source drives data/valid/last; the sink answers with ready.
interface pixel_packet_writer_if;
   logic [7:0] s_data;
   logic       s_valid;
   logic       s_last;
   logic       s_ready;

   modport master (
      output s_data,
      output s_valid,
      output s_last,
      input  s_ready
   );

   modport slave (
      input  s_data,
      input  s_valid,
      input  s_last,
      output s_ready
   );
endinterface

// File: rtl/pixel_packet_writer.sv
// Pixel packet writer: parses PIX / FILL packets from a byte stream and
// turns them into single-cycle writes on the LED driver's video-memory port.
module pixel_packet_writer #(
   parameter int CHAINED     = 1,
   parameter int INPUT_DEPTH = 6
) (
   input  logic                  ctrl_clk,
   input  logic                  ctrl_rst,
   pixel_packet_writer_if.slave  s_bus,
   output logic                  ctrl_en,
   output logic [3:0]            ctrl_wr,
   output logic [15:0]           ctrl_addr,
   output logic [23:0]           ctrl_wdat,
   output logic                  busy,
   output logic                  err
);

   localparam int SIZE_BITS = $clog2(CHAINED);
   localparam int COL_W     = 6 + SIZE_BITS;
   // The column counter must be able to hold 64*CHAINED, where it saturates.
   localparam int CNT_W     = (COL_W + 1 > 8) ? COL_W + 1 : 8;
   localparam int FILL_W    = 12 + SIZE_BITS;
   localparam int SHIFT     = 8 - INPUT_DEPTH;

   localparam logic [CNT_W-1:0]  COL_LIMIT = CNT_W'(64 * CHAINED);
   localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(4096 * CHAINED - 1);
   localparam logic [3:0]        WR_RGB    = 4'b0111;

   localparam logic [3:0] IDLE     = 4'd0;
   localparam logic [3:0] PIX_ROW  = 4'd1;
   localparam logic [3:0] PIX_COL  = 4'd2;
   localparam logic [3:0] PIX_R    = 4'd3;
   localparam logic [3:0] PIX_G    = 4'd4;
   localparam logic [3:0] PIX_B    = 4'd5;
   localparam logic [3:0] FILL_R   = 4'd6;
   localparam logic [3:0] FILL_G   = 4'd7;
   localparam logic [3:0] FILL_B   = 4'd8;
   localparam logic [3:0] FILL_RUN = 4'd9;
   localparam logic [3:0] DROP     = 4'd10;

   logic [3:0]        state_q;
   logic [5:0]        row_q;
   logic [CNT_W-1:0]  col_q;
   logic [7:0]        r_q;
   logic [7:0]        g_q;
   logic [FILL_W-1:0] fill_q;
   logic              ovf_q;     // err already raised for this packet's overflow
   logic              xfer;
   logic              last;
   logic [7:0]        data;

   // Drop the low bits of an 8-bit channel, leaving it right-aligned.
   function automatic logic [7:0] reduce(input logic [7:0] c);
      return c >> SHIFT;
   endfunction

   assign data          = s_bus.s_data;
   assign last          = s_bus.s_last;
   assign s_bus.s_ready = (state_q != FILL_RUN);
   assign xfer          = s_bus.s_valid && s_bus.s_ready;

   // Packet parser, fill sequencer and registered write port.
   always_ff @(posedge ctrl_clk) begin
      // NOTE: reset is synchronous, so it lives inside the clocked block and
      // is simply the highest-priority branch; all state uses <= so every
      // register sees the values from before this edge.
      if (ctrl_rst) begin
         state_q   <= IDLE;
         row_q     <= '0;
         col_q     <= '0;
         r_q       <= '0;
         g_q       <= '0;
         fill_q    <= '0;
         ovf_q     <= 1'b0;
         ctrl_en   <= 1'b0;
         ctrl_wr   <= '0;
         ctrl_addr <= '0;
         ctrl_wdat <= '0;
         busy      <= 1'b0;
         err       <= 1'b0;
      end else begin
         // Strobes are single-cycle; addr/wdat deliberately hold.
         ctrl_en <= 1'b0;
         ctrl_wr <= '0;
         err     <= 1'b0;

         if (state_q == FILL_RUN) begin
            if (fill_q == FILL_LAST) begin
               state_q <= IDLE;
               busy    <= 1'b0;
            end else begin
               fill_q    <= fill_q + FILL_W'(1);
               ctrl_en   <= 1'b1;
               ctrl_wr   <= WR_RGB;
               ctrl_addr <= 16'(fill_q + FILL_W'(1));
            end
         end else if (xfer) begin
            case (state_q)
               IDLE: begin
                  ovf_q <= 1'b0;
                  if (data == 8'h01) begin
                     state_q <= PIX_ROW;
                  end else if (data == 8'h02) begin
                     state_q <= FILL_R;
                  end else begin
                     err     <= 1'b1;
                     state_q <= last ? IDLE : DROP;
                  end
               end
               PIX_ROW: begin
                  if (last) begin
                     err     <= 1'b1;
                     state_q <= IDLE;
                  end else if (data > 8'd63) begin
                     err     <= 1'b1;
                     state_q <= DROP;
                  end else begin
                     row_q   <= data[5:0];
                     state_q <= PIX_COL;
                  end
               end
               PIX_COL: begin
                  if (last) begin
                     err     <= 1'b1;
                     state_q <= IDLE;
                  end else begin
                     col_q   <= CNT_W'(data);
                     state_q <= PIX_R;
                  end
               end
               PIX_R, FILL_R: begin
                  if (last) begin
                     err     <= 1'b1;
                     state_q <= IDLE;
                  end else begin
                     r_q     <= data;
                     state_q <= (state_q == PIX_R) ? PIX_G : FILL_G;
                  end
               end
               PIX_G, FILL_G: begin
                  if (last) begin
                     err     <= 1'b1;
                     state_q <= IDLE;
                  end else begin
                     g_q     <= data;
                     state_q <= (state_q == PIX_G) ? PIX_B : FILL_B;
                  end
               end
               PIX_B: begin
                  if (col_q < COL_LIMIT) begin
                     ctrl_en   <= 1'b1;
                     ctrl_wr   <= WR_RGB;
                     ctrl_addr <= 16'({row_q, col_q[COL_W-1:0]});
                     ctrl_wdat <= {reduce(r_q), reduce(g_q), reduce(data)};
                     col_q     <= col_q + CNT_W'(1);
                  end else if (!ovf_q) begin
                     err   <= 1'b1;
                     ovf_q <= 1'b1;
                  end
                  state_q <= last ? IDLE : PIX_R;
               end
               FILL_B: begin
                  if (last) begin
                     // First fill write goes out with the state change.
                     state_q   <= FILL_RUN;
                     busy      <= 1'b1;
                     fill_q    <= '0;
                     ctrl_en   <= 1'b1;
                     ctrl_wr   <= WR_RGB;
                     ctrl_addr <= '0;
                     ctrl_wdat <= {reduce(r_q), reduce(g_q), reduce(data)};
                  end else begin
                     err     <= 1'b1;
                     state_q <= DROP;
                  end
               end
               DROP: begin
                  if (last) state_q <= IDLE;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pixel_packet_writer.sv
// Directed bench for pixel_packet_writer (CHAINED=1, INPUT_DEPTH=6).
module tb_pixel_packet_writer;

   logic        ctrl_clk = 1'b0;
   logic        ctrl_rst;
   logic        ctrl_en;
   logic [3:0]  ctrl_wr;
   logic [15:0] ctrl_addr;
   logic [23:0] ctrl_wdat;
   logic        busy;
   logic        err;

   pixel_packet_writer_if bus();

   pixel_packet_writer #(.CHAINED(1), .INPUT_DEPTH(6)) dut (
      .ctrl_clk  (ctrl_clk),
      .ctrl_rst  (ctrl_rst),
      .s_bus     (bus.slave),
      .ctrl_en   (ctrl_en),
      .ctrl_wr   (ctrl_wr),
      .ctrl_addr (ctrl_addr),
      .ctrl_wdat (ctrl_wdat),
      .busy      (busy),
      .err       (err)
   );

   always #5 ctrl_clk = ~ctrl_clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Observed writes as {wr, addr, wdat}; event counters sampled mid-cycle.
   logic [43:0] wq[$];
   int err_cnt  = 0;
   int busy_cyc = 0;
   int nrdy_cyc = 0;
   int wr_bad   = 0;

   always @(negedge ctrl_clk) begin
      if (!ctrl_rst) begin
         if (ctrl_en) wq.push_back({ctrl_wr, ctrl_addr, ctrl_wdat});
         if (err) err_cnt++;
         if (busy) busy_cyc++;
         if (!bus.s_ready) nrdy_cyc++;
         if (ctrl_wr != (ctrl_en ? 4'b0111 : 4'b0000)) wr_bad++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge ctrl_clk);
      #1;
   endtask

   // Present one byte and hold it until the handshake edge has passed.
   task automatic send(input logic [7:0] d, input logic l);
      int n;
      bus.s_data  = d;
      bus.s_last  = l;
      bus.s_valid = 1'b1;
      n = 0;
      @(negedge ctrl_clk);
      while (!bus.s_ready && n < 6000) begin
         @(negedge ctrl_clk);
         n++;
      end
      if (n >= 6000) check("ready_timeout", 32'(n), 32'd0);
      @(posedge ctrl_clk);
      #1;
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
   endtask

   // Idle gap with junk on data/last that must be ignored.
   task automatic gap();
      bus.s_valid = 1'b0;
      bus.s_data  = 8'hEE;
      bus.s_last  = 1'b1;
      tick(2);
      bus.s_last  = 1'b0;
   endtask

   task automatic check_write(input string tag, input int idx,
                              input logic [15:0] addr, input logic [23:0] wdat);
      logic [43:0] e;
      e = (idx < wq.size()) ? wq[idx] : 44'h0;
      check({tag, "_addr"}, 32'(e[39:24]), 32'(addr));
      check({tag, "_wdat"}, 32'(e[23:0]), 32'(wdat));
      check({tag, "_wr"},   32'(e[43:40]), 32'h7);
   endtask

   initial begin
      int base;
      int e0;
      int b0;
      int r0;
      int n;
      int bad;
      logic [43:0] e;

      bus.s_valid = 1'b0;
      bus.s_data  = 8'h00;
      bus.s_last  = 1'b0;
      ctrl_rst    = 1'b1;
      tick(3);
      check("rst_en",    32'(ctrl_en),   32'd0);
      check("rst_wr",    32'(ctrl_wr),   32'd0);
      check("rst_addr",  32'(ctrl_addr), 32'd0);
      check("rst_wdat",  32'(ctrl_wdat), 32'd0);
      check("rst_busy",  32'(busy),      32'd0);
      check("rst_err",   32'(err),       32'd0);
      check("rst_ready", 32'(bus.s_ready), 32'd1);
      ctrl_rst = 1'b0;
      tick(1);

      // Single pixel: row 5, col 10, RGB FC/80/04.
      base = wq.size();
      e0   = err_cnt;
      send(8'h01, 0); send(8'h05, 0); send(8'h0A, 0);
      send(8'hFC, 0); send(8'h80, 0); send(8'h04, 1);
      check("t1_en_next", 32'(ctrl_en), 32'd1);
      tick(1);
      check("t1_en_once", 32'(ctrl_en), 32'd0);
      tick(3);
      check("t1_count", 32'(wq.size() - base), 32'd1);
      check_write("t1", base, 16'h014A, 24'h3F2001);
      check("t1_addr_hold", 32'(ctrl_addr), 32'h014A);
      check("t1_err", 32'(err_cnt - e0), 32'd0);

      // Row end: col 62 with four pixels, two written, err once.
      base = wq.size();
      e0   = err_cnt;
      send(8'h01, 0); send(8'h3F, 0); send(8'h3E, 0);
      send(8'h10, 0); send(8'h20, 0); send(8'h30, 0);
      send(8'h40, 0); send(8'h50, 0); send(8'h60, 0);
      send(8'h70, 0); send(8'h80, 0); send(8'h90, 0);
      send(8'hA0, 0); send(8'hB0, 0); send(8'hC0, 1);
      tick(3);
      check("t2_count", 32'(wq.size() - base), 32'd2);
      check_write("t2_w0", base,     16'h0FFE, 24'h04080C);
      check_write("t2_w1", base + 1, 16'h0FFF, 24'h101418);
      check("t2_err", 32'(err_cnt - e0), 32'd1);

      // Whole-screen fill.
      base = wq.size();
      b0   = busy_cyc;
      r0   = nrdy_cyc;
      send(8'h02, 0); send(8'hFF, 0); send(8'h00, 0); send(8'h40, 1);
      check("t3_busy_on", 32'(busy), 32'd1);
      n = 0;
      while (busy && n < 5000) begin
         @(negedge ctrl_clk);
         n++;
      end
      check("t3_done", 32'(busy), 32'd0);
      tick(2);
      check("t3_ready", 32'(bus.s_ready), 32'd1);
      check("t3_busy_cyc", 32'(busy_cyc - b0), 32'd4096);
      check("t3_nrdy_cyc", 32'(nrdy_cyc - r0), 32'd4096);
      check("t3_count", 32'(wq.size() - base), 32'd4096);
      bad = 0;
      for (int i = 0; i < 4096 && base + i < wq.size(); i++) begin
         e = wq[base + i];
         if (e[39:24] != 16'(i) || e[23:0] != 24'h3F0010 || e[43:40] != 4'h7) bad++;
      end
      check("t3_seq", 32'(bad), 32'd0);
      check_write("t3_last", base + 4095, 16'h0FFF, 24'h3F0010);

      // Unknown command is dropped, then a PIX goes through.
      base = wq.size();
      e0   = err_cnt;
      send(8'h07, 0); send(8'h11, 0); send(8'h22, 0);
      send(8'h33, 0); send(8'h44, 0); send(8'h55, 1);
      tick(2);
      check("t4_nowrite", 32'(wq.size() - base), 32'd0);
      check("t4_err", 32'(err_cnt - e0), 32'd1);
      send(8'h01, 0); send(8'h02, 0); send(8'h03, 0);
      send(8'h44, 0); send(8'h88, 0); send(8'hCC, 1);
      tick(2);
      check("t4_count", 32'(wq.size() - base), 32'd1);
      check_write("t4", base, 16'h0083, 24'h112233);

      // Truncated PIX, then a valid packet with idle gaps.
      base = wq.size();
      e0   = err_cnt;
      send(8'h01, 0); send(8'h04, 0); send(8'h07, 0);
      send(8'hAA, 0); send(8'hBB, 1);
      tick(2);
      check("t5_nowrite", 32'(wq.size() - base), 32'd0);
      check("t5_err", 32'(err_cnt - e0), 32'd1);
      send(8'h01, 0); gap(); send(8'h06, 0); gap(); send(8'h09, 0); gap();
      send(8'h08, 0); gap(); send(8'h0C, 0); gap(); send(8'hF0, 1);
      tick(2);
      check("t5_count", 32'(wq.size() - base), 32'd1);
      check_write("t5", base, 16'h0189, 24'h02033C);
      check("t5_err_total", 32'(err_cnt - e0), 32'd1);

      // Reset in the middle of a fill.
      send(8'h02, 0); send(8'h04, 0); send(8'h08, 0); send(8'h0C, 1);
      n = 0;
      while (!(ctrl_en && ctrl_addr == 16'h0200) && n < 5000) begin
         @(negedge ctrl_clk);
         n++;
      end
      check("t6_reach_200", 32'(ctrl_addr), 32'h0200);
      ctrl_rst = 1'b1;
      @(negedge ctrl_clk);
      check("t6_en",    32'(ctrl_en), 32'd0);
      check("t6_busy",  32'(busy), 32'd0);
      check("t6_ready", 32'(bus.s_ready), 32'd1);
      ctrl_rst = 1'b0;
      tick(1);
      base = wq.size();
      tick(20);
      check("t6_nowrite", 32'(wq.size() - base), 32'd0);
      send(8'h01, 0); send(8'h00, 0); send(8'h00, 0);
      send(8'h04, 0); send(8'h08, 0); send(8'h0C, 1);
      tick(2);
      check("t6_count", 32'(wq.size() - base), 32'd1);
      check_write("t6", base, 16'h0000, 24'h010203);

      check("wr_strobe", 32'(wr_bad), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
